// File: rtl/accelerator_state_matrix_feeder.sv
// Transmit-side element feeder: FIFO-buffered host elements streamed row-major with I/J enables.
// Optional sticky stall flag: define ACCELERATOR_STATE_MATRIX_FEEDER_UNDERRUN_EN.
module accelerator_state_matrix_feeder #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 4,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 ready,
   input  logic [DATA_SIZE-1:0] size_i_in,
   input  logic [DATA_SIZE-1:0] size_j_in,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   input  logic                 data_out_req,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 data_out_i_enable,
   output logic                 data_out_j_enable
`ifdef ACCELERATOR_STATE_MATRIX_FEEDER_UNDERRUN_EN
   ,
   output logic                 underrun
`endif
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [DATA_SIZE-1:0] ONE        = DATA_SIZE'(1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CONTROL_SIZE < 1) begin : g_bad_cfg
      $error("accelerator_state_matrix_feeder: invalid parameter set");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                 state_r;
   logic [DATA_SIZE-1:0]   mem_r [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [CNT_W-1:0]       count_r;
   logic [DATA_SIZE-1:0]   size_i_r;
   logic [DATA_SIZE-1:0]   size_j_r;
   logic [DATA_SIZE-1:0]   index_i_r;
   logic [DATA_SIZE-1:0]   index_j_r;
   logic [DATA_SIZE-1:0]   data_out_r;
   logic                   i_enable_r;
   logic                   j_enable_r;
   logic                   ready_r;
   logic                   underrun_r;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;
   logic last_j_s;
   logic last_i_s;

   assign full_s   = (count_r == FULL_COUNT);
   assign empty_s  = (count_r == '0);
   assign push_s   = data_in_valid & ~full_s;
   assign pop_s    = (state_r == ST_STREAM) & data_out_req & ~empty_s;
   assign last_j_s = (index_j_r == size_j_r - ONE);
   assign last_i_s = (index_i_r == size_i_r - ONE);

   assign data_in_ready     = ~full_s;
   assign ready             = ready_r;
   assign data_out          = data_out_r;
   assign data_out_i_enable = i_enable_r;
   assign data_out_j_enable = j_enable_r;
`ifdef ACCELERATOR_STATE_MATRIX_FEEDER_UNDERRUN_EN
   assign underrun          = underrun_r;
`endif

   // FIFO storage; contents are meaningless once the pointers are reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Stream sequencer with registered element, strobes and completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         size_i_r   <= '0;
         size_j_r   <= '0;
         index_i_r  <= '0;
         index_j_r  <= '0;
         data_out_r <= '0;
         i_enable_r <= 1'b0;
         j_enable_r <= 1'b0;
         ready_r    <= 1'b0;
         underrun_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ready_r    <= 1'b0;
               i_enable_r <= 1'b0;
               j_enable_r <= 1'b0;
               if (start) begin
                  size_i_r   <= size_i_in;
                  size_j_r   <= size_j_in;
                  index_i_r  <= '0;
                  index_j_r  <= '0;
                  underrun_r <= 1'b0;
                  if (size_i_in == '0 || size_j_in == '0) begin
                     state_r <= ST_DONE;
                     ready_r <= 1'b1;
                  end else begin
                     state_r <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (data_out_req && empty_s) begin
                  underrun_r <= 1'b1;
               end
               if (pop_s) begin
                  data_out_r <= mem_r[rd_ptr_r];
                  j_enable_r <= 1'b1;
                  i_enable_r <= (index_j_r == '0);
                  if (last_j_s) begin
                     index_j_r <= '0;
                     index_i_r <= index_i_r + ONE;
                     // READY rises together with the final strobe
                     if (last_i_s) begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b1;
                     end
                  end else begin
                     index_j_r <= index_j_r + ONE;
                  end
               end else begin
                  j_enable_r <= 1'b0;
                  i_enable_r <= 1'b0;
               end
            end
            ST_DONE: begin
               ready_r    <= 1'b0;
               i_enable_r <= 1'b0;
               j_enable_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
            default: begin
               ready_r    <= 1'b0;
               i_enable_r <= 1'b0;
               j_enable_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accelerator_state_matrix_feeder.sv
// Directed bench for accelerator_state_matrix_feeder; hand-computed expectations.
module tb_accelerator_state_matrix_feeder;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          ready;
   logic [DW-1:0] size_i_in;
   logic [DW-1:0] size_j_in;
   logic [DW-1:0] data_in;
   logic          data_in_valid;
   logic          data_in_ready;
   logic          data_out_req;
   logic [DW-1:0] data_out;
   logic          data_out_i_enable;
   logic          data_out_j_enable;
`ifdef ACCELERATOR_STATE_MATRIX_FEEDER_UNDERRUN_EN
   logic          underrun;
`endif

   int num_checks = 0;
   int num_errors = 0;

   always #5 clk = ~clk;

   accelerator_state_matrix_feeder #(
      .DATA_SIZE(DW), .CONTROL_SIZE(4), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
      .size_i_in(size_i_in), .size_j_in(size_j_in),
      .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .data_out_req(data_out_req), .data_out(data_out),
      .data_out_i_enable(data_out_i_enable), .data_out_j_enable(data_out_j_enable)
`ifdef ACCELERATOR_STATE_MATRIX_FEEDER_UNDERRUN_EN
      , .underrun(underrun)
`endif
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] val);
      data_in       = val;
      data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
   endtask

   task automatic kick(input logic [DW-1:0] si, input logic [DW-1:0] sj);
      size_i_in = si;
      size_j_in = sj;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [10:0] strobe_map;
      logic [DW-1:0] exp_val;

      rst_n = 1'b0; start = 1'b0; size_i_in = '0; size_j_in = '0;
      data_in = '0; data_in_valid = 1'b0; data_out_req = 1'b0;
      step(); step();
      check_eq("rst_ready", ready, 64'd0);
      check_eq("rst_in_ready", data_in_ready, 64'd1);
      check_eq("rst_data_out", data_out, 64'd0);
      check_eq("rst_j_en", data_out_j_enable, 64'd0);
      check_eq("rst_i_en", data_out_i_enable, 64'd0);
      rst_n = 1'b1;
      step();

      // 2x3 preloaded, REQ held high
      for (int k = 0; k < 6; k++) push(64'(k + 1));
      data_out_req = 1'b1;
      kick(64'd2, 64'd3);
      check_eq("m23_no_strobe_yet", data_out_j_enable, 64'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("m23_data", data_out, 64'(k + 1));
         check_eq("m23_j_en", data_out_j_enable, 64'd1);
         check_eq("m23_i_en", data_out_i_enable, (k == 0 || k == 3) ? 64'd1 : 64'd0);
         check_eq("m23_ready", ready, (k == 5) ? 64'd1 : 64'd0);
      end
      step();
      check_eq("m23_ready_drop", ready, 64'd0);
      check_eq("m23_j_drop", data_out_j_enable, 64'd0);
      data_out_req = 1'b0;

      // zero-size START leaves FIFO untouched; leftovers feed the next matrix
      push(64'hA); push(64'hB);
      kick(64'd0, 64'd4);
      check_eq("zero_ready", ready, 64'd1);
      check_eq("zero_j_en", data_out_j_enable, 64'd0);
      step();
      check_eq("zero_ready_drop", ready, 64'd0);
      check_eq("zero_count", 64'(dut.count_r), 64'd2);
      data_out_req = 1'b1;
      kick(64'd1, 64'd2);
      step();
      check_eq("left_data0", data_out, 64'hA);
      check_eq("left_i0", data_out_i_enable, 64'd1);
      step();
      check_eq("left_data1", data_out, 64'hB);
      check_eq("left_i1", data_out_i_enable, 64'd0);
      check_eq("left_ready", ready, 64'd1);
      data_out_req = 1'b0;
      step();

      // fill to capacity; ninth push refused
      for (int k = 0; k < 8; k++) begin
         check_eq("fill_ready", data_in_ready, 64'd1);
         push(64'(16 + k));
      end
      check_eq("full_ready", data_in_ready, 64'd0);
      check_eq("full_count", 64'(dut.count_r), 64'd8);
      push(64'h99);
      check_eq("ninth_count", 64'(dut.count_r), 64'd8);
      data_out_req = 1'b1;
      kick(64'd1, 64'd1);
      data_in = 64'h77; data_in_valid = 1'b1;
      step();
      data_in_valid = 1'b0;
      check_eq("full_pop_data", data_out, 64'd16);
      check_eq("full_pop_ready", ready, 64'd1);
      check_eq("full_pop_in_ready", data_in_ready, 64'd1);
      check_eq("full_pop_count", 64'(dut.count_r), 64'd7);
      data_out_req = 1'b0;
      step();
      rst_n = 1'b0; step(); rst_n = 1'b1; step();
      check_eq("flush_count", 64'(dut.count_r), 64'd0);

      // 1x4 with REQ toggling and a push every third cycle
      kick(64'd1, 64'd4);
      strobe_map = 11'b101_0001_0100;
      exp_val = 64'h41;
      for (int c = 0; c < 11; c++) begin
         data_out_req  = (c % 2 == 0);
         data_in_valid = (c % 3 == 0);
         data_in       = 64'(65 + c / 3);
         step();
         check_eq("trk_j_en", data_out_j_enable, 64'(strobe_map[c]));
         check_eq("trk_ready", ready, (c == 10) ? 64'd1 : 64'd0);
         if (strobe_map[c]) begin
            check_eq("trk_data", data_out, exp_val);
            check_eq("trk_i_en", data_out_i_enable, (c == 2) ? 64'd1 : 64'd0);
            exp_val = exp_val + 64'd1;
         end
      end
      data_in_valid = 1'b0; data_out_req = 1'b0;
      step();

      // asynchronous reset mid-stream
      for (int k = 0; k < 6; k++) push(64'(32 + k));
      data_out_req = 1'b1;
      kick(64'd2, 64'd3);
      step(); step();
      check_eq("mid_second", data_out, 64'd33);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_data", data_out, 64'd0);
      check_eq("mid_rst_j", data_out_j_enable, 64'd0);
      check_eq("mid_rst_i", data_out_i_enable, 64'd0);
      check_eq("mid_rst_ready", ready, 64'd0);
      check_eq("mid_rst_in_ready", data_in_ready, 64'd1);
      step();
      rst_n = 1'b1;
      data_out_req = 1'b0;
      push(64'hC3);
      data_out_req = 1'b1;
      kick(64'd1, 64'd1);
      step();
      check_eq("post_rst_data", data_out, 64'hC3);
      check_eq("post_rst_i", data_out_i_enable, 64'd1);
      check_eq("post_rst_j", data_out_j_enable, 64'd1);
      check_eq("post_rst_ready", ready, 64'd1);
      data_out_req = 1'b0;
      step();

`ifdef ACCELERATOR_STATE_MATRIX_FEEDER_UNDERRUN_EN
      push(64'h51);
      kick(64'd1, 64'd2);
      data_out_req = 1'b1;
      step();
      check_eq("udr_first_pop", data_out, 64'h51);
      check_eq("udr_clear", underrun, 64'd0);
      step();
      check_eq("udr_set", underrun, 64'd1);
      check_eq("udr_stall_j", data_out_j_enable, 64'd0);
      step();
      check_eq("udr_sticky", underrun, 64'd1);
      push(64'h52);
      step();
      check_eq("udr_last", data_out, 64'h52);
      check_eq("udr_last_ready", ready, 64'd1);
      check_eq("udr_hold", underrun, 64'd1);
      data_out_req = 1'b0;
      step();
      kick(64'd0, 64'd0);
      check_eq("udr_start_clear", underrun, 64'd0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
